// File: rtl/xm23_clock_control.sv
// xm23_clock_control: divides clk_in into the XM23 CPU clock, releases the PC init force, counts CPU cycles until the finish instruction
//
// Ports:
//   clk_in      board clock, every state change happens on its rising edge
//   init        synchronous active-high reset, highest priority
//   speed       selects the half-period entry of DIV_TABLE
//   run         1 = free-run, 0 = paused / single-step (step build only)
//   step        step request level (step build only)
//   inst        instruction currently fetched, sampled on every CPU rise
//   clk_out     registered divided CPU clock
//   rise_pulse  high in the first clk_in cycle that clk_out reads 1
//   pc_force    holds the init fetch address until the first CPU rise
//   led         toggles on every CPU rise
//   halted      sticky, finish instruction seen on a rise
//   cycle_count saturating count of CPU rises before halt
//   overflow    sticky, increment attempted at saturation
//
// Build option: define XM23_CLKCTL_STEP_EN for run/step single-step control;
// without it run and step are ignored and the divider free-runs.
module xm23_clock_control #(
    parameter int                          NUM_SPEEDS  = 4,
    parameter int                          DIV_W       = 32,
    parameter logic [NUM_SPEEDS*DIV_W-1:0] DIV_TABLE   = {32'd3, 32'd250_000, 32'd2_500_000, 32'd25_000_000},
    parameter int                          CNT_W       = 64,
    parameter logic [15:0]                 FINISH_INST = 16'h3FFF
) (
    input  logic                          clk_in,
    input  logic                          init,
    input  logic [$clog2(NUM_SPEEDS)-1:0] speed,
    input  logic                          run,
    input  logic                          step,
    input  logic [15:0]                   inst,
    output logic                          clk_out,
    output logic                          rise_pulse,
    output logic                          pc_force,
    output logic                          led,
    output logic                          halted,
    output logic [CNT_W-1:0]              cycle_count,
    output logic                          overflow
);
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_sel;
    logic             clk_out_q, clk_out_d, rise_pulse_q, rise_pulse_d, pc_force_q, pc_force_d;
    logic             led_q, led_d, halted_q, halted_d, overflow_q, overflow_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             active, drain, en, term, toggle, rise;

    assign div_sel = DIV_TABLE[DIV_W*speed +: DIV_W];
    // once nothing keeps the divider active, a high half still runs to its
    // fall and a low half runs out its count, but never toggles upward
    assign drain  = !active && (clk_out_q || cnt_q != '0);
    assign en     = active || drain;
    assign term   = cnt_q == div_q - 1'b1;
    assign toggle = en && term && (active || clk_out_q);
    assign rise   = toggle && !clk_out_q;

`ifdef XM23_CLKCTL_STEP_EN
    typedef enum logic [1:0] {IDLE, HIGH, LOW} step_e;
    step_e state_q, state_d;
    logic  step_q;

    // a step only starts from a fully stopped divider so HIGH always sees a rise next
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!run && step && !step_q && !clk_out_q && cnt_q == '0) state_d = HIGH;
            HIGH:    if (toggle) state_d = run ? IDLE : LOW;
            LOW:     if (toggle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign active = run || state_q != IDLE;

    always_ff @(posedge clk_in) begin
        if (init) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = run ^ step;
    assign active    = 1'b1;
`endif

    always_comb begin
        cnt_d         = en ? (term ? '0 : cnt_q + 1'b1) : cnt_q;
        div_d         = (en && term) ? div_sel : div_q;
        clk_out_d     = toggle ? !clk_out_q : clk_out_q;
        rise_pulse_d  = rise;
        pc_force_d    = rise ? 1'b0 : pc_force_q;
        led_d         = rise ? !led_q : led_q;
        halted_d      = halted_q;
        overflow_d    = overflow_q;
        cycle_count_d = cycle_count_q;
        if (rise) begin
            if (inst == FINISH_INST) halted_d = 1'b1;
            else if (!halted_q) begin
                if (&cycle_count_q) overflow_d = 1'b1;
                else cycle_count_d = cycle_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (init) begin
            cnt_q         <= '0;
            div_q         <= div_sel;
            clk_out_q     <= 1'b0;
            rise_pulse_q  <= 1'b0;
            pc_force_q    <= 1'b1;
            led_q         <= 1'b0;
            halted_q      <= 1'b0;
            overflow_q    <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            clk_out_q     <= clk_out_d;
            rise_pulse_q  <= rise_pulse_d;
            pc_force_q    <= pc_force_d;
            led_q         <= led_d;
            halted_q      <= halted_d;
            overflow_q    <= overflow_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign rise_pulse  = rise_pulse_q;
    assign pc_force    = pc_force_q;
    assign led         = led_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_xm23_clock_control.sv
// tb_xm23_clock_control: scoreboard bench for xm23_clock_control
module tb_xm23_clock_control;
    localparam logic [15:0] FIN = 16'h3FFF;

    logic        clk = 1'b0;
    logic        init0 = 1'b1, run0 = 1'b1, step0 = 1'b0, init1 = 1'b1, run1 = 1'b1, step1 = 1'b0;
    logic [1:0]  speed0 = 2'd3, speed1 = 2'd3;
    logic [15:0] inst0 = 16'h0, inst1 = 16'h0;
    logic        clk0, rp0, pcf0, led0, hlt0, ovf0, clk1, rp1, pcf1, led1, hlt1, ovf1;
    logic [63:0] cnt0;
    logic [3:0]  cnt1;

    typedef struct {string tag; int sel; logic [63:0] v;} item_t;
    item_t sb[$];
    int    n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    xm23_clock_control u0 (
        .clk_in(clk), .init(init0), .speed(speed0), .run(run0), .step(step0), .inst(inst0),
        .clk_out(clk0), .rise_pulse(rp0), .pc_force(pcf0), .led(led0), .halted(hlt0),
        .cycle_count(cnt0), .overflow(ovf0)
    );

    xm23_clock_control #(.DIV_TABLE({32'd8, 32'd4, 32'd2, 32'd1}), .CNT_W(4)) u1 (
        .clk_in(clk), .init(init1), .speed(speed1), .run(run1), .step(step1), .inst(inst1),
        .clk_out(clk1), .rise_pulse(rp1), .pc_force(pcf1), .led(led1), .halted(hlt1),
        .cycle_count(cnt1), .overflow(ovf1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            0:       return {63'd0, clk0};
            1:       return {63'd0, rp0};
            2:       return {63'd0, pcf0};
            3:       return {63'd0, led0};
            4:       return {63'd0, hlt0};
            5:       return cnt0;
            6:       return {63'd0, ovf0};
            10:      return {63'd0, clk1};
            11:      return {63'd0, rp1};
            15:      return {60'd0, cnt1};
            16:      return {63'd0, ovf1};
            default: return 64'hx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [63:0] v);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.v   = v;
        sb.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            check(it.tag, obs(it.sel), it.v);
        end
    end

    task automatic run_u0();
        int r;
        // free-run at D=3
        inst0 = 16'h0;
        init0 = 1'b1;
        tick();
        init0 = 1'b0;
        for (int n = 0; n <= 20; n++) begin
            r = n >= 3 ? (n - 3) / 6 + 1 : 0;
            expect_v($sformatf("fr clk c%0d", n), 0, 64'(n >= 3 && (n - 3) % 6 < 3));
            expect_v($sformatf("fr rise c%0d", n), 1, 64'(n >= 3 && (n - 3) % 6 == 0));
            expect_v($sformatf("fr pcf c%0d", n), 2, 64'(n < 3));
            expect_v($sformatf("fr led c%0d", n), 3, 64'(r % 2));
            expect_v($sformatf("fr cnt c%0d", n), 5, 64'(r));
            if (n == 0) begin
                expect_v("rst halted", 4, 64'd0);
                expect_v("rst ovf", 6, 64'd0);
            end
            tick();
        end
        // finish instruction on the 5th rise, then init mid high half
        init0 = 1'b1;
        tick();
        init0 = 1'b0;
        for (int n = 0; n <= 89; n++) begin
            inst0 = n == 26 ? FIN : 16'h0;
            init0 = n == 88;
            r = n >= 3 ? (n - 3) / 6 + 1 : 0;
            if (n <= 88) begin
                expect_v($sformatf("fin clk c%0d", n), 0, 64'(n >= 3 && (n - 3) % 6 < 3));
                expect_v($sformatf("fin halted c%0d", n), 4, 64'(n >= 27));
                expect_v($sformatf("fin cnt c%0d", n), 5, 64'(n < 27 ? r : 4));
                expect_v($sformatf("fin led c%0d", n), 3, 64'(r % 2));
            end else begin
                expect_v("init clk", 0, 64'd0);
                expect_v("init rise", 1, 64'd0);
                expect_v("init pcf", 2, 64'd1);
                expect_v("init led", 3, 64'd0);
                expect_v("init halted", 4, 64'd0);
                expect_v("init cnt", 5, 64'd0);
                expect_v("init ovf", 6, 64'd0);
            end
            tick();
        end
`ifdef XM23_CLKCTL_STEP_EN
        // single step while paused; second step edge lands inside the step
        run0  = 1'b0;
        init0 = 1'b1;
        tick();
        init0 = 1'b0;
        for (int n = 0; n <= 30; n++) begin
            step0 = n == 10 || n == 12;
            expect_v($sformatf("stp clk c%0d", n), 0, 64'(n >= 14 && n <= 16));
            expect_v($sformatf("stp rise c%0d", n), 1, 64'(n == 14));
            expect_v($sformatf("stp pcf c%0d", n), 2, 64'(n < 14));
            expect_v($sformatf("stp cnt c%0d", n), 5, 64'(n >= 14));
            tick();
        end
        step0 = 1'b0;
`endif
    endtask

    task automatic run_u1();
        int r;
        // D=8 latched at reset, speed drops to D=1 mid low half; 4-bit saturation
        speed1 = 2'd3;
        init1  = 1'b1;
        tick();
        init1 = 1'b0;
        for (int n = 0; n <= 44; n++) begin
            speed1 = n >= 4 ? 2'd0 : 2'd3;
            r = n >= 8 ? (n - 8) / 2 + 1 : 0;
            expect_v($sformatf("spd clk c%0d", n), 10, 64'(n >= 8 && (n - 8) % 2 == 0));
            expect_v($sformatf("spd rise c%0d", n), 11, 64'(n >= 8 && (n - 8) % 2 == 0));
            expect_v($sformatf("sat cnt c%0d", n), 15, 64'(r > 15 ? 15 : r));
            expect_v($sformatf("sat ovf c%0d", n), 16, 64'(r >= 16));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        fork
            run_u0();
            run_u1();
        join
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
